// File: rtl/wb_cmd_master.sv
// Wishbone classic master: turns a valid/ready command stream into single 32-bit
// bus cycles through a 2-entry FIFO, returning one response per command.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and a raised valid holds its payload until taken.

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam bit                   TO_EN  = (TIMEOUT_CYCLES != 0);

    state_t               state;
    logic [64:0]          fifo_mem [0:1];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [1:0]           count_nxt;
    logic                 ready_q;
    logic                 push;
    logic                 pop;
    logic [64:0]          head;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign push      = cmd_valid_i && ready_q;
    assign pop       = (state == IDLE) && (count != 2'd0);
    assign head      = fifo_mem[rd_ptr];
    assign cnt_inc   = cnt + 1'b1;

    assign cmd_ready_o = ready_q;
    assign busy_o      = (state != IDLE) || (count != 2'd0);
    assign wbm_sel_o   = 4'hF;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_we_i, cmd_adr_i, cmd_dat_i};
        end
    end

    // Ready is a register of the next occupancy, so a pop never opens it combinationally.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_adr_o     <= 32'h0;
            wbm_dat_o     <= 32'h0;
            rsp_valid_o   <= 1'b0;
            rsp_dat_o     <= 32'h0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        wbm_we_o  <= head[64];
                        wbm_adr_o <= head[63:32];
                        wbm_dat_o <= head[31:0];
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins a tie with the timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_dat_o     <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (TO_EN && (cnt_inc == TO_VAL)) begin
                        cnt           <= cnt_inc;
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_dat_o     <= 32'h0;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (cnt != TO_VAL) begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic initiator (master) that turns a simple valid/ready command stream into single 32-bit bus read/write cycles, and returns one response per command.
- Lets a local controller (button sequencer, debug UART, test logic) drive the user-area peripherals on the shared Wishbone bus, such as the LED/button register block.
- Contains a 2-entry command FIFO, a transaction FSM and an ack timeout counter.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUS without ack before the transaction is aborted. 0 disables the timeout (wait forever).
- TIMEOUT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  sole clock; all logic is on its rising edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  FIFO can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data; ignored for reads.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_dat_o  out  32  read data; 0 for writes and timeouts.
- rsp_timeout_o  out  1  transaction aborted by timeout.
- busy_o  out  1  FSM not IDLE or FIFO not empty.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; constant 4'hF.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  responder ack.

Behaviour:
- Reset (async, wb_rst_n_i low) clears:
  - All outputs to 0, except wbm_sel_o = 4'hF. cmd_ready_o goes to 1 after reset release.
  - FIFO emptied, FSM to IDLE, timeout counter to 0.
  - Reset mid-transaction drops cyc/stb immediately; the in-flight command and any queued commands are discarded and no response is produced.
- FIFO:
  - 2 entries of {we, adr, dat}.
  - cmd_ready_o = occupancy < 2, from registered occupancy only (not combinational on pop). When full, ready stays low even in a cycle where a pop occurs.
  - Push on cmd_valid_i && cmd_ready_o. Simultaneous push and pop at occupancy 1 leaves occupancy 1. Order is strictly FIFO.
- FSM states IDLE, BUS, RESP:
  - IDLE -> BUS when the FIFO is non-empty. That edge pops the head, loads wbm_we_o/wbm_adr_o/wbm_dat_o, sets cyc=stb=1 and clears the counter. cyc/stb first appear in the cycle after the FIFO head is visible.
  - In BUS, cyc, stb, we, adr and dat are held stable. The counter increments each cycle with ack low.
  - BUS, on an edge sampling wbm_ack_i = 1: cyc=stb=0 at that edge. rsp_dat_o is loaded with wbm_dat_i for reads and 0 for writes; rsp_timeout_o=0; rsp_valid_o=1; go to RESP.
  - BUS, when the counter reaches TIMEOUT_CYCLES with TIMEOUT_CYCLES != 0 and ack low: cyc=stb=0; rsp_dat_o=0; rsp_timeout_o=1; rsp_valid_o=1; go to RESP.
  - If ack and timeout coincide, ack wins.
  - RESP: hold rsp_* until rsp_valid_o && rsp_ready_i. At that edge rsp_valid_o=0 and go to IDLE. rsp_dat_o/rsp_timeout_o keep their value until the next response.
  - Minimum spacing: IDLE, then at least 1 BUS cycle, then 1 RESP cycle. cyc is deasserted for at least 2 cycles between transactions.
- wbm_ack_i outside BUS is ignored, e.g. the trailing ack from a registered-ack responder one cycle after stb drops.
- Width rules:
  - The counter saturates at TIMEOUT_CYCLES and never wraps.
  - Addresses are passed unmodified; no alignment check.

Test Plan:
- Write: push {we=1, adr=0x3000_0000, dat=0x0000_00A5}; responder acks 1 cycle after stb -> one cycle with cyc=stb=we=1, adr/dat stable; then rsp_valid=1, rsp_dat=0, rsp_timeout=0; responder LED reg reads 0xA5.
- Read: push {we=0, adr=0x3000_0004}; responder returns 0x0000_0005 with ack -> rsp_dat=0x0000_0005. The stray ack in the cycle after stb drops causes no second response.
- Timeout: TIMEOUT_CYCLES=4, read 0x3000_0100 with no ack -> cyc/stb high for exactly 4 cycles, then rsp_timeout=1, rsp_dat=0. A later valid command completes normally.
- Backpressure: hold rsp_ready=0, push 3 commands back-to-back -> cmd_ready falls after queue fills. Releasing rsp_ready yields 3 responses in order, each transaction only after the previous response is taken.
- Reset mid-transaction: assert wb_rst_n_i low during BUS with 1 queued command -> cyc/stb low in the same cycle without a clock edge. After release, busy_o=0, rsp_valid=0, cmd_ready=1, and no bus activity.
- Ack/timeout tie: TIMEOUT_CYCLES=3, ack arrives on the 3rd BUS cycle -> rsp_timeout=0 and the read data is captured.
